lab4_ifetch: RTL

LAB4_IFETCH -- requirements
Module: lab4_ifetch

---
 rtl/lab4_pkg.sv | 15 +
 rtl/lab4_fetch_buf.sv | 56 +++++
 rtl/lab4_ifetch.sv | 71 +++++++
 3 files changed

// File: rtl/lab4_pkg.sv
// Shared widths, the halt marker and the {pc, instr} entry type for the
// instruction fetch unit and its buffer.
package lab4_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;

    localparam logic [INSTR_W-1:0] HALT_WORD = 16'h0000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

endpackage

// File: rtl/lab4_fetch_buf.sv
// Two-entry FIFO of fetched {pc, instr} pairs; the head entry is always
// the oldest one and drives decode directly.
module lab4_fetch_buf
    import lab4_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  entry_t     din,
    output entry_t     head,
    output logic [1:0] count
);

    entry_t slot1;
    logic   do_pop;

    assign do_pop = pop && (count != 2'd0);

    // A push into a full buffer without a pop is never requested by the
    // fetch logic, so that case simply leaves the contents alone.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            count <= 2'd0;
            head  <= '0;
            slot1 <= '0;
        end else begin
            case ({push, do_pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head  <= din;
                        count <= 2'd1;
                    end else if (count == 2'd1) begin
                        slot1 <= din;
                        count <= 2'd2;
                    end
                end
                2'b01: begin
                    head  <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= din;
                    end else begin
                        head  <= slot1;
                        slot1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/lab4_ifetch.sv
// Instruction fetch: walks the fetch PC through instruction memory, buffers
// up to two words for decode, stops on a halt marker and restarts on redirect.
module lab4_ifetch
    import lab4_pkg::*;
#(
    parameter logic [7:0] RESET_PC     = 8'h00,
    parameter bit         HALT_ON_ZERO = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic [7:0]  IMEM_ADDR,
    input  logic [15:0] IMEM_Q,
    output logic [15:0] INSTR,
    output logic [7:0]  PC_OUT,
    output logic        VALID,
    input  logic        READY,
    input  logic        REDIRECT,
    input  logic [7:0]  REDIRECT_PC,
    output logic        HALT
);

    logic [7:0] fpc;
    logic       halted;
    logic [1:0] count;
    logic       pop;
    logic       push_ok;
    logic       halt_hit;
    logic       push;
    entry_t     head;

    // Handshake: VALID means INSTR/PC_OUT hold the oldest buffered word;
    // it is consumed on any cycle where VALID and READY are both 1, and
    // INSTR/PC_OUT stay stable while VALID=1 and READY=0.
    assign VALID     = (count != 2'd0);
    assign pop       = VALID && READY;
    assign INSTR     = head.instr;
    assign PC_OUT    = head.pc;
    assign HALT      = halted && (count == 2'd0);
    assign IMEM_ADDR = {fpc[7:1], 1'b0};

    assign push_ok  = !halted && !REDIRECT && ((count != 2'd2) || pop);
    assign halt_hit = push_ok && HALT_ON_ZERO && (IMEM_Q == HALT_WORD);
    assign push     = push_ok && !halt_hit;

    lab4_fetch_buf u_buf (
        .clk   (CLK),
        .rst_n (RESET),
        .flush (REDIRECT),
        .push  (push),
        .pop   (pop),
        .din   ('{pc: fpc, instr: IMEM_Q}),
        .head  (head),
        .count (count)
    );

    // Redirect outranks everything; the pc arithmetic wraps FE -> 00 naturally.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            fpc    <= RESET_PC & 8'hFE;
            halted <= 1'b0;
        end else if (REDIRECT) begin
            fpc    <= REDIRECT_PC & 8'hFE;
            halted <= 1'b0;
        end else if (halt_hit) begin
            halted <= 1'b1;
        end else if (push) begin
            fpc <= fpc + 8'd2;
        end
    end

endmodule
